// File: rtl/inst_fetch_resp.sv
// inst_fetch_resp: instruction-fetch responder.
// It issues reads to a synchronous instruction RAM on behalf of the PC register.
// Returned words are captured with their PC into a 2-entry buffer that feeds decode.
// A branch/jump flush drops everything fetched but not yet delivered.
module inst_fetch_resp #(
  parameter int XLEN    = 32,
  parameter int IRAM_AW = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               iram_en,
  input  logic [XLEN-1:0]    pc_i,
  input  logic               pipe_stall,
  input  logic               bj_flag,
  output logic               iram_ce_o,
  output logic [IRAM_AW-1:0] iram_addr_o,
  input  logic [31:0]        iram_rdata_i,
  output logic               inst_valid_o,
  output logic [31:0]        inst_o,
  output logic [XLEN-1:0]    inst_pc_o,
  output logic               inst_misalign_o,
  output logic               ovf_err_o
);

  // Buffer entry layout: {instruction word, pc, misalign flag}
  localparam int EW = 32 + XLEN + 1;

  logic            acc;
  logic            push;
  logic            pop;
  logic [EW-1:0]   entry;

  logic            req_vld_q, req_vld_d;
  logic [XLEN-1:0] req_pc_q,  req_pc_d;
  logic            req_mis_q, req_mis_d;

  logic [EW-1:0]   mem_q [0:1];
  logic [EW-1:0]   mem_d [0:1];
  logic            rd_ptr_q, rd_ptr_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic [1:0]      cnt_q,    cnt_d;
  logic [EW-1:0]   head_q,   head_d;
  logic            vld_q,    vld_d;
  logic            ovf_q,    ovf_d;

  // A flush cycle never issues a read: pc_i still holds the stale sequential address.
  assign acc         = iram_en & ~pipe_stall & ~bj_flag;
  assign iram_ce_o   = acc;
  assign iram_addr_o = pc_i[IRAM_AW+1:2];

  assign push  = req_vld_q;
  assign pop   = vld_q & ~pipe_stall;
  assign entry = {iram_rdata_i, req_pc_q, req_mis_q};

  assign inst_valid_o    = vld_q;
  assign inst_o          = head_q[EW-1 -: 32];
  assign inst_pc_o       = head_q[XLEN:1];
  assign inst_misalign_o = head_q[0];
  assign ovf_err_o       = ovf_q;

  // Track the outstanding RAM read so its PC can be paired with the returned word.
  always_comb begin
    req_vld_d = acc;
    req_pc_d  = req_pc_q;
    req_mis_d = req_mis_q;
    if (acc) begin
      req_pc_d  = pc_i;
      req_mis_d = |pc_i[1:0];
    end else begin
      req_pc_d  = req_pc_q;
      req_mis_d = req_mis_q;
    end
  end

  // Buffer next state: flush wins, otherwise push/pop with overflow detection.
  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    head_d   = head_q;
    vld_d    = vld_q;
    if (bj_flag) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      cnt_d    = 2'd0;
      head_d   = {EW{1'b0}};
      vld_d    = 1'b0;
    end else begin
      case ({push, pop})
        2'b11: begin
          // When full, the write slot is the head being popped, so overwriting it is safe.
          mem_d[wr_ptr_q] = entry;
          wr_ptr_d        = ~wr_ptr_q;
          rd_ptr_d        = ~rd_ptr_q;
        end
        2'b10: begin
          if (cnt_q == 2'd2) begin
            ovf_d = 1'b1;
          end else begin
            mem_d[wr_ptr_q] = entry;
            wr_ptr_d        = ~wr_ptr_q;
            cnt_d           = cnt_q + 2'd1;
          end
        end
        2'b01: begin
          rd_ptr_d = ~rd_ptr_q;
          cnt_d    = cnt_q - 2'd1;
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
      // Head follows the slot the read pointer lands on; unchanged when no pop and no push into empty.
      head_d = mem_d[rd_ptr_d];
      vld_d  = (cnt_d != 2'd0);
    end
  end

  // Request tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_vld_q <= 1'b0;
      req_pc_q  <= {XLEN{1'b0}};
      req_mis_q <= 1'b0;
    end else begin
      req_vld_q <= req_vld_d;
      req_pc_q  <= req_pc_d;
      req_mis_q <= req_mis_d;
    end
  end

  // Buffer storage, pointers, registered head and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= {EW{1'b0}};
      mem_q[1] <= {EW{1'b0}};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      head_q   <= {EW{1'b0}};
      vld_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      vld_q    <= vld_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Directed testbench for inst_fetch_resp: a small PC register and instruction RAM
// surround the DUT; every expected value below is hand-computed.
// RAM word at word address A is 0x1000_0000 | A.
module tb_inst_fetch_resp;

  logic        clk;
  logic        rst_n;
  logic        iram_en;
  logic [31:0] pc_q;
  logic        pipe_stall;
  logic        bj_flag;
  logic [31:0] bj_target;
  logic        iram_ce_o;
  logic [11:0] iram_addr_o;
  logic [31:0] iram_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_misalign_o;
  logic        ovf_err_o;

  int err_cnt = 0;
  int chk_cnt = 0;

  inst_fetch_resp #(.XLEN(32), .IRAM_AW(12)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .iram_en         (iram_en),
    .pc_i            (pc_q),
    .pipe_stall      (pipe_stall),
    .bj_flag         (bj_flag),
    .iram_ce_o       (iram_ce_o),
    .iram_addr_o     (iram_addr_o),
    .iram_rdata_i    (iram_rdata_i),
    .inst_valid_o    (inst_valid_o),
    .inst_o          (inst_o),
    .inst_pc_o       (inst_pc_o),
    .inst_misalign_o (inst_misalign_o),
    .ovf_err_o       (ovf_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register model: branch target on flush, +4 when fetching and not stalled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       pc_q <= 32'h0;
    else if (bj_flag)                 pc_q <= bj_target;
    else if (iram_en && !pipe_stall)  pc_q <= pc_q + 32'd4;
  end

  // Synchronous instruction RAM model.
  always @(posedge clk) begin
    if (iram_ce_o) iram_rdata_i <= 32'h1000_0000 | {20'h0, iram_addr_o};
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; iram_en = 1'b0; pipe_stall = 1'b0; bj_flag = 1'b0; bj_target = 32'h0;
    iram_rdata_i = 32'h0;
    #12;
    check_eq("rst_valid", 64'(inst_valid_o), 64'(0));
    check_eq("rst_inst",  64'(inst_o), 64'(0));
    check_eq("rst_pc",    64'(inst_pc_o), 64'(0));
    check_eq("rst_mis",   64'(inst_misalign_o), 64'(0));
    check_eq("rst_ovf",   64'(ovf_err_o), 64'(0));
    check_eq("rst_ce",    64'(iram_ce_o), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    tick(); tick();

    // Sequential fetch
    iram_en = 1'b1; #1;
    check_eq("seq_ce",   64'(iram_ce_o), 64'(1));
    check_eq("seq_addr", 64'(iram_addr_o), 64'(0));
    tick();
    check_eq("seq_lat_v0", 64'(inst_valid_o), 64'(0));
    tick();
    check_eq("seq_v1",   64'(inst_valid_o), 64'(1));
    check_eq("seq_pc0",  64'(inst_pc_o), 64'(32'h0));
    check_eq("seq_i0",   64'(inst_o), 64'(32'h1000_0000));
    tick();
    check_eq("seq_pc4",  64'(inst_pc_o), 64'(32'h4));
    check_eq("seq_i4",   64'(inst_o), 64'(32'h1000_0001));
    tick();
    check_eq("seq_pc8",  64'(inst_pc_o), 64'(32'h8));
    check_eq("seq_i8",   64'(inst_o), 64'(32'h1000_0002));

    // Stall for 3 cycles with head 0x8, 0xC in flight
    pipe_stall = 1'b1; #1;
    check_eq("stall_ce", 64'(iram_ce_o), 64'(0));
    tick();
    check_eq("stall_pc_a", 64'(inst_pc_o), 64'(32'h8));
    check_eq("stall_cnt",  64'(dut.cnt_q), 64'(2));
    tick();
    check_eq("stall_pc_b", 64'(inst_pc_o), 64'(32'h8));
    check_eq("stall_i_b",  64'(inst_o), 64'(32'h1000_0002));
    tick();
    pipe_stall = 1'b0;
    check_eq("rel_pc8", 64'(inst_pc_o), 64'(32'h8));
    check_eq("rel_ovf", 64'(ovf_err_o), 64'(0));
    tick();
    check_eq("rel_pcC",  64'(inst_pc_o), 64'(32'hC));
    check_eq("rel_iC",   64'(inst_o), 64'(32'h1000_0003));
    tick();
    check_eq("rel_pc10", 64'(inst_pc_o), 64'(32'h10));
    check_eq("rel_v10",  64'(inst_valid_o), 64'(1));

    // Flush with head 0x10, 0x14 in flight, target 0x100
    bj_flag = 1'b1; bj_target = 32'h100; #1;
    check_eq("fl_ce", 64'(iram_ce_o), 64'(0));
    tick();
    bj_flag = 1'b0; #1;
    check_eq("fl_v1",    64'(inst_valid_o), 64'(0));
    check_eq("fl_ce1",   64'(iram_ce_o), 64'(1));
    check_eq("fl_addr1", 64'(iram_addr_o), 64'(12'h40));
    tick();
    check_eq("fl_v2", 64'(inst_valid_o), 64'(0));
    tick();
    check_eq("fl_v3",  64'(inst_valid_o), 64'(1));
    check_eq("fl_pc3", 64'(inst_pc_o), 64'(32'h100));
    check_eq("fl_i3",  64'(inst_o), 64'(32'h1000_0040));
    tick();
    check_eq("fl_pc4", 64'(inst_pc_o), 64'(32'h104));

    // Flush during stall with a full buffer, target 0x200
    pipe_stall = 1'b1;
    tick();
    check_eq("fs_cnt", 64'(dut.cnt_q), 64'(2));
    bj_flag = 1'b1; bj_target = 32'h200; #1;
    check_eq("fs_ce", 64'(iram_ce_o), 64'(0));
    tick();
    bj_flag = 1'b0; pipe_stall = 1'b0; #1;
    check_eq("fs_v0",   64'(inst_valid_o), 64'(0));
    check_eq("fs_cnt0", 64'(dut.cnt_q), 64'(0));
    tick();
    check_eq("fs_v1", 64'(inst_valid_o), 64'(0));
    tick();
    check_eq("fs_v2",  64'(inst_valid_o), 64'(1));
    check_eq("fs_pc2", 64'(inst_pc_o), 64'(32'h200));
    check_eq("fs_i2",  64'(inst_o), 64'(32'h1000_0080));

    // Misaligned target 0x6
    bj_flag = 1'b1; bj_target = 32'h6;
    tick();
    bj_flag = 1'b0; #1;
    check_eq("mis_addr", 64'(iram_addr_o), 64'(1));
    tick(); tick();
    check_eq("mis_pc",   64'(inst_pc_o), 64'(32'h6));
    check_eq("mis_flag", 64'(inst_misalign_o), 64'(1));
    check_eq("mis_i",    64'(inst_o), 64'(32'h1000_0001));

    // Overflow: fill during stall, then inject an extra push
    pipe_stall = 1'b1;
    tick();
    check_eq("ovf_pre", 64'(ovf_err_o), 64'(0));
    force dut.req_vld_q = 1'b1;
    tick();
    release dut.req_vld_q;
    check_eq("ovf_set",  64'(ovf_err_o), 64'(1));
    check_eq("ovf_head", 64'(inst_pc_o), 64'(32'h6));
    tick();
    pipe_stall = 1'b0;
    tick(); tick();
    check_eq("ovf_sticky", 64'(ovf_err_o), 64'(1));

    // Reset mid-operation
    #2;
    rst_n = 1'b0; #1;
    check_eq("mrst_valid", 64'(inst_valid_o), 64'(0));
    check_eq("mrst_inst",  64'(inst_o), 64'(0));
    check_eq("mrst_pc",    64'(inst_pc_o), 64'(0));
    check_eq("mrst_ovf",   64'(ovf_err_o), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    tick();
    check_eq("rs_v0", 64'(inst_valid_o), 64'(0));
    tick();
    check_eq("rs_v1",  64'(inst_valid_o), 64'(1));
    check_eq("rs_pc0", 64'(inst_pc_o), 64'(32'h0));
    check_eq("rs_i0",  64'(inst_o), 64'(32'h1000_0000));
    tick();
    check_eq("rs_pc4", 64'(inst_pc_o), 64'(32'h4));

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
